// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg: shared types and constants for the bus-side word memory.
package bus_memory_pkg;

  localparam int PADDR_W = 20;

  typedef enum logic [1:0] {
    BM_IDLE,
    BM_ARMED,
    BM_READ
  } bm_state_e;

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] data;
  } bm_word_t;

endpackage

// File: rtl/bus_memory_array.sv
// bus_memory_array: single-port synchronous 72-bit RAM with write enable and registered read.
// Deliberately reset-free so it can later be replaced by a vendor RAM macro.
module bus_memory_array
  import bus_memory_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  bm_word_t          i_wdata,
  output bm_word_t          o_rdata
);

  bm_word_t r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/bus_memory.sv
// bus_memory: 64-bit data + 8-bit tag word memory driven by the CPU bus port.
// Define BUS_MEMORY_PROTECT_EN to build per-page write protection (prot_* ports, wforce override).
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int PAGE_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     astb,
  input  logic [63:0]              ad_in,
  input  logic [7:0]               tag_in,
  input  logic                     rd,
  input  logic                     wr,
  input  logic                     wforce,
  output logic [63:0]              data_out,
  output logic [7:0]               tag_out,
  output logic                     dvalid,
  output logic                     busy,
  output logic                     fault,
  input  logic                     prot_we,
  input  logic [ADDR_W-PAGE_W-1:0] prot_page,
  input  logic                     prot_val
);

  bm_state_e         r_state;
  bm_state_e         w_stateNext;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_count;
  logic [1:0]        w_countNext;
  logic              r_dvalid;
  logic              w_dvalidNext;
  logic              r_fault;
  logic              w_faultNext;
  bm_word_t          r_hold;
  bm_word_t          w_rdata;
  bm_word_t          w_wdata;
  logic [PADDR_W-1:0] w_paddr;
  logic              w_unusedPaddr;
  logic              w_accept;
  logic              w_rdGo;
  logic              w_wrTry;
  logic              w_wrGo;
  logic              w_protHit;

  assign w_paddr       = ad_in[PADDR_W-1:0];
  assign w_unusedPaddr = ^w_paddr;
  assign w_wdata       = {tag_in, ad_in};

  // A request is only legal in ARMED, alone, and not shadowed by an address strobe.
  assign w_accept = !astb && (r_state == BM_ARMED) && (rd != wr);
  assign w_rdGo   = w_accept && rd;
  assign w_wrTry  = w_accept && wr;
  assign w_wrGo   = w_wrTry && !(w_protHit && !wforce);
  assign w_faultNext = ((rd || wr) && !w_accept) || (w_wrTry && !w_wrGo);

`ifdef BUS_MEMORY_PROTECT_EN
  logic [(1<<(ADDR_W-PAGE_W))-1:0] r_prot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prot <= '0;
    else if (prot_we) r_prot[prot_page] <= prot_val;
  end

  assign w_protHit = r_prot[r_addr[ADDR_W-1:PAGE_W]];
`else
  logic w_unusedProt;
  assign w_unusedProt = ^{prot_we, prot_page, prot_val};
  assign w_protHit    = 1'b0;
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_dvalidNext = 1'b0;
    if (r_state == BM_READ) begin
      w_countNext = r_count - 2'd1;
      if (r_count == 2'd1) begin
        w_dvalidNext = 1'b1;
        w_stateNext  = BM_ARMED;
      end
    end else if (astb) begin
      w_stateNext = BM_ARMED;
    end else if (w_rdGo) begin
      w_countNext = 2'(READ_LAT - 1);
      if (READ_LAT == 1) w_dvalidNext = 1'b1;
      else               w_stateNext  = BM_READ;
    end
  end

  // The address register is updated by astb even mid-read; the array already captured the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= BM_IDLE;
      r_addr   <= '0;
      r_count  <= '0;
      r_dvalid <= 1'b0;
      r_fault  <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_dvalid <= w_dvalidNext;
      r_fault  <= w_faultNext;
      if (astb) r_addr <= w_paddr[ADDR_W-1:0];
      if (r_dvalid) r_hold <= w_rdata;
    end
  end

  bus_memory_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wrGo),
    .i_re    (w_rdGo),
    .i_addr  (r_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign data_out = r_dvalid ? w_rdata.data : r_hold.data;
  assign tag_out  = r_dvalid ? w_rdata.tag  : r_hold.tag;
  assign dvalid   = r_dvalid;
  assign busy     = (r_state == BM_READ);
  assign fault    = r_fault;

endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: three bus_memory instances (READ_LAT 1, 3, 4) on shared stimulus,
// each compared every cycle against a transaction-level reference model.
module tb_bus_memory;

  localparam int NDUT = 3;
`ifdef BUS_MEMORY_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        astb;
  logic [63:0] adIn;
  logic [7:0]  tagIn;
  logic        rd;
  logic        wr;
  logic        wforce;
  logic        protWe;
  logic [4:0]  protPage;
  logic        protVal;

  logic [63:0] dataOut  [NDUT];
  logic [7:0]  tagOut   [NDUT];
  logic        dvOut    [NDUT];
  logic        busyOut  [NDUT];
  logic        faultOut [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    bus_memory #(
      .ADDR_W   (15),
      .PAGE_W   (10),
      .READ_LAT (g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) uDut (
      .clk       (clk),
      .reset     (reset),
      .astb      (astb),
      .ad_in     (adIn),
      .tag_in    (tagIn),
      .rd        (rd),
      .wr        (wr),
      .wforce    (wforce),
      .data_out  (dataOut[g]),
      .tag_out   (tagOut[g]),
      .dvalid    (dvOut[g]),
      .busy      (busyOut[g]),
      .fault     (faultOut[g]),
      .prot_we   (protWe),
      .prot_page (protPage),
      .prot_val  (protVal)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words keyed by instance and address, reads as a remaining-edges counter.
  logic [71:0] mMem [int];
  bit          mHave      [NDUT];
  int          mAddr      [NDUT];
  int          mRem       [NDUT];
  logic [71:0] mPend      [NDUT];
  bit          mPendKnown [NDUT];
  logic [71:0] mHold      [NDUT];
  bit          mHoldKnown [NDUT];
  bit          mDv        [NDUT];
  bit          mFault     [NDUT];
  bit          mProt      [NDUT][32];

  int checks;
  int errors;
  logic [14:0] pool [8];

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NDUT; i++) begin
      mHave[i]      = 1'b0;
      mAddr[i]      = 0;
      mRem[i]       = 0;
      mPend[i]      = '0;
      mPendKnown[i] = 1'b1;
      mHold[i]      = '0;
      mHoldKnown[i] = 1'b1;
      mDv[i]        = 1'b0;
      mFault[i]     = 1'b0;
      for (int p = 0; p < 32; p++) mProt[i][p] = 1'b0;
    end
  endtask

  task automatic deliver(input int i);
    mDv[i]        = 1'b1;
    mHold[i]      = mPend[i];
    mHoldKnown[i] = mPendKnown[i];
  endtask

  task automatic modelEdge();
    for (int i = 0; i < NDUT; i++) begin
      bit busyNow;
      int key;
      int page;
      busyNow   = (mRem[i] > 0);
      mDv[i]    = 1'b0;
      mFault[i] = 1'b0;
      if (busyNow) begin
        mRem[i]--;
        if (mRem[i] == 0) deliver(i);
      end
      if (astb) begin
        mAddr[i] = int'(adIn[14:0]);
        mHave[i] = 1'b1;
        if (rd || wr) mFault[i] = 1'b1;
      end else if (rd || wr) begin
        key = i * 32768 + mAddr[i];
        if ((rd && wr) || !mHave[i] || busyNow) begin
          mFault[i] = 1'b1;
        end else if (rd) begin
          mPendKnown[i] = (mMem.exists(key) != 0);
          mPend[i]      = mPendKnown[i] ? mMem[key] : 72'h0;
          mRem[i]       = latOf(i) - 1;
          if (mRem[i] == 0) deliver(i);
        end else begin
          page = mAddr[i] / 1024;
          if (PROT_EN && mProt[i][page] && !wforce) mFault[i] = 1'b1;
          else mMem[key] = {tagIn, adIn};
        end
      end
      if (protWe) mProt[i][protPage] = protVal;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("dvalid_L%0d", latOf(i)), 64'(dvOut[i]), 64'(mDv[i]));
      checkOutput($sformatf("busy_L%0d", latOf(i)), 64'(busyOut[i]), 64'(mRem[i] > 0));
      checkOutput($sformatf("fault_L%0d", latOf(i)), 64'(faultOut[i]), 64'(mFault[i]));
      if (mHoldKnown[i]) begin
        checkOutput($sformatf("data_L%0d", latOf(i)), dataOut[i], mHold[i][63:0]);
        checkOutput($sformatf("tag_L%0d", latOf(i)), 64'(tagOut[i]), 64'(mHold[i][71:64]));
      end
    end
  endtask

  task automatic applyStimulus(input logic a, input logic [63:0] ad, input logic [7:0] tg,
                               input logic r, input logic w, input logic wf,
                               input logic pwe, input logic [4:0] pp, input logic pv);
    astb = a; adIn = ad; tagIn = tg; rd = r; wr = w; wforce = wf;
    protWe = pwe; protPage = pp; protVal = pv;
    @(posedge clk);
    if (!reset) modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 64'h0, 8'h0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic strobe(input logic [63:0] a);
    applyStimulus(1, a, 8'h0, 0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic writeWord(input logic [63:0] d, input logic [7:0] t, input logic wf);
    applyStimulus(0, d, t, 0, 1, wf, 0, 5'd0, 0);
  endtask

  task automatic readReq();
    applyStimulus(0, 64'h0, 8'h0, 1, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic setProt(input logic [4:0] page, input logic val);
    applyStimulus(0, 64'h0, 8'h0, 0, 0, 0, 1, page, val);
  endtask

  task automatic doReset();
    astb = 0; rd = 0; wr = 0; wforce = 0; protWe = 0;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 0; astb = 0; adIn = '0; tagIn = '0; rd = 0; wr = 0; wforce = 0;
    protWe = 0; protPage = '0; protVal = 0;
    pool = '{15'h0123, 15'h0010, 15'h0400, 15'h07FF, 15'h2C01, 15'h5555, 15'h7FFF, 15'h4000};
    modelReset();
    #2;
    doReset();
    $display("[TB] reset done");

    readReq();
    checkOutput("idle_rd_fault", 64'(faultOut[0]), 64'd1);
    idle(1);
    checkOutput("idle_rd_no_dvalid", 64'(dvOut[0]), 64'd0);

    strobe(64'h00123);
    writeWord(64'hDEADBEEF_01234567, 8'h35, 0);
    readReq();
    checkOutput("wtr_dvalid", 64'(dvOut[0]), 64'd1);
    checkOutput("wtr_data", dataOut[0], 64'hDEADBEEF_01234567);
    checkOutput("wtr_tag", 64'(tagOut[0]), 64'h35);
    idle(4);

    strobe(64'h08123);
    readReq();
    checkOutput("lat3_busy1", 64'(busyOut[1]), 64'd1);
    idle(1);
    checkOutput("lat3_busy2", 64'(busyOut[1]), 64'd1);
    idle(1);
    checkOutput("lat3_dvalid", 64'(dvOut[1]), 64'd1);
    checkOutput("lat3_data", dataOut[1], 64'hDEADBEEF_01234567);
    idle(3);

    strobe(64'h0010);
    writeWord(64'h1111_1111_1111_1111, 8'hA1, 0);
    setProt(5'd0, 1);
    writeWord(64'h2222_2222_2222_2222, 8'hA2, 0);
    readReq();
    idle(4);
    writeWord(64'h3333_3333_3333_3333, 8'hA3, 1);
    checkOutput("wforce_no_fault", 64'(faultOut[0]), 64'd0);
    readReq();
    checkOutput("wforce_data", dataOut[0], 64'h3333_3333_3333_3333);
    idle(4);
    applyStimulus(0, 64'h4444_4444_4444_4444, 8'hA4, 0, 1, 0, 1, 5'd0, 0);
    readReq();
    idle(4);
    writeWord(64'h5555_5555_5555_5555, 8'hA5, 0);
    readReq();
    checkOutput("unprot_data", dataOut[0], 64'h5555_5555_5555_5555);
    idle(4);

    strobe(64'h00123);
    applyStimulus(0, 64'hBAD0_BAD0_BAD0_BAD0, 8'hEE, 1, 1, 1, 0, 5'd0, 0);
    checkOutput("rdwr_fault", 64'(faultOut[0]), 64'd1);
    readReq();
    checkOutput("rdwr_unchanged", dataOut[0], 64'hDEADBEEF_01234567);
    idle(4);

    strobe(64'h00123);
    readReq();
    idle(1);
    doReset();
    checkOutput("rst_mid_dvalid", 64'(dvOut[2]), 64'd0);
    checkOutput("rst_mid_data", dataOut[2], 64'd0);
    checkOutput("rst_mid_busy", 64'(busyOut[2]), 64'd0);
    idle(3);
    readReq();
    checkOutput("rst_idle_fault", 64'(faultOut[2]), 64'd1);
    idle(1);
    strobe(64'h00123);
    readReq();
    idle(3);
    checkOutput("rst_keep_dvalid", 64'(dvOut[2]), 64'd1);
    checkOutput("rst_keep_data", dataOut[2], 64'hDEADBEEF_01234567);
    idle(1);

    for (int k = 0; k < 8; k++) begin
      strobe({49'h0, pool[k]});
      writeWord({$urandom(), $urandom()}, 8'($urandom()), 1);
    end
    strobe({49'h0, pool[2]});
    for (int k = 0; k < 4; k++) readReq();
    strobe({49'h0, pool[3]});
    readReq();
    readReq();
    idle(4);
    $display("[TB] directed steps done, starting random traffic");

    for (int n = 0; n < 800; n++) begin
      logic [63:0] a;
      int k;
      bit s;
      a = {$urandom(), $urandom()};
      k = $urandom_range(0, 7);
      s = ($urandom_range(0, 99) < 15);
      if (s) a[14:0] = pool[k];
      applyStimulus(s, a, 8'($urandom()), $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 6, 5'(pool[k] >> 10),
                    $urandom_range(0, 1) == 1);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_memory.md
# bus_memory

Synthesizable word memory that sits directly downstream of the `cpu` bus port. It consumes `o_ad`/`o_tag`/`o_astb`/`o_rd`/`o_wr`/`o_wforce` and produces the `i_data`/`i_tag` words the CPU loads and fetches. Each word is 64 data bits plus an 8-bit tag. Per-page write protection can be overridden by `wforce`. It replaces the constant-zero data inputs used in microcode-only benches, so tests that execute real instruction streams can run.

## Interface
Parameters:
- `ADDR_W`, 15: log2 of words stored; upper physical-address bits are ignored (wrap).
- `PAGE_W`, 10: log2 of words per protection page.
- `READ_LAT`, 1: cycles from the `rd` sample to `dvalid`; legal range 1..4.

Ports:
- `clk`  in  1: single clock; every flop is on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `astb`  in  1: address strobe; `ad_in[19:0]` is the physical address.
- `ad_in`  in  64: address (on the `astb` cycle) or write data.
- `tag_in`  in  8: write tag.
- `rd`  in  1: read request.
- `wr`  in  1: write request.
- `wforce`  in  1: when sampled with `wr`, ignore protection.
- `data_out`  out  64: read data → CPU `i_data`.
- `tag_out`  out  8: read tag → CPU `i_tag`.
- `dvalid`  out  1: one-cycle pulse; `data_out`/`tag_out` are valid.
- `busy`  out  1: a read is in flight, so `rd`/`wr` are ignored.
- `fault`  out  1: one-cycle pulse on a refused access.
- `prot_we`  in  1: write one protection bit.
- `prot_page`  in  `ADDR_W-PAGE_W`: page index for `prot_we`.
- `prot_val`  in  1: 1 means the page is protected.

## Operation
- States: IDLE (no address), ARMED (address latched), READ (latency countdown).
- `astb` latches `addr = ad_in[ADDR_W-1:0]` in any state, including during READ.
  - An in-flight read completes with its original address.
  - The state goes to ARMED, or stays READ until the countdown ends and then goes to ARMED.
- ARMED + `rd`:
  - Captures the word at `addr` and loads the countdown with `READ_LAT-1`.
  - If `READ_LAT` is 1, the state stays ARMED and `dvalid` pulses the next cycle.
  - Otherwise the state goes to READ and `busy` is 1 until `dvalid`.
- ARMED + `wr`:
  - Writes `{tag_in, ad_in}` to `addr` at that edge, unless the page `addr[ADDR_W-1:PAGE_W]` is protected and `wforce`=0.
  - A refused write leaves the array unchanged and pulses `fault`.
- `rd` and `wr` together: neither is performed; `fault` pulses.
- `rd`/`wr` in IDLE or while `busy`=1: ignored; `fault` pulses.
- `astb` together with `rd`/`wr`: `astb` wins; the request is ignored and `fault` pulses.
- The address is held after an access, so repeated `rd`/`wr` without a new `astb` reuse it.
- `data_out`/`tag_out` hold their last read value between pulses.
- Protection: `prot_we` updates one bit per cycle.
  - The update takes effect for a `wr` sampled on the following edge.
  - A simultaneous `prot_we` and `wr` to the same page uses the old bit.

## Timing
- Reset values:
  - `data_out`=0, `tag_out`=0, `dvalid`=0, `busy`=0, `fault`=0.
  - State IDLE, `addr`=0, countdown=0.
  - All protection bits are 0.
- The memory array is not reset.
- Read: `rd` sampled at edge E gives `dvalid`=1 in the cycle after edge E+READ_LAT-1.
- Back-to-back reads every cycle are sustained at `READ_LAT`=1.
- Write: the array is updated at the sampling edge. A `rd` on the next cycle returns the new word (no bypass needed beyond write-then-read ordering).
- `fault` is registered: it is high in the cycle after the offending sample.
- `reset` asserted mid-read drops the pending read immediately, with no `dvalid`.

## Configuration
- `BUS_MEMORY_PROTECT_EN` defined:
  - Protection bit array, `prot_*` ports and protection-refusal faults are present.
- `BUS_MEMORY_PROTECT_EN` undefined:
  - `prot_*` inputs are ignored and no storage is built.
  - Every legal `wr` is performed regardless of `wforce`.
  - `fault` still reports protocol errors.

## Structure
- A shared package `bus_memory_pkg` holds:
  - The state enum (`BM_IDLE`, `BM_ARMED`, `BM_READ`).
  - The word type `struct packed {logic [7:0] tag; logic [63:0] data;}`.
  - The `PADDR_W`=20 constant.
- One sub-module, `bus_memory_array`, is a single-port synchronous 72-bit RAM. It has a write enable and a registered read, so it can later be mapped to a vendor macro.

## Test plan
- Write then read:
  - `astb` with `ad_in`=0x00123, then `wr` with data 0xDEADBEEF_01234567 and tag 0x35, then `rd`.
  - Expect `dvalid` 1 cycle later with that data and tag 0x35.
- Latency and wrap:
  - With `READ_LAT`=3, `astb` address 0x08123 (wraps to 0x0123), then `rd`.
  - Expect `busy` high for 2 cycles, `dvalid` in the 3rd cycle, and the word from the previous test.
- Protection:
  - Set `prot_we` with page 0 and `prot_val`=1, then `wr` to address 0x0010 with `wforce`=0.
  - Expect a `fault` pulse and the old word read back.
  - Repeat with `wforce`=1: the write is performed and there is no `fault`.
- Protocol errors:
  - `rd` in IDLE after reset gives a `fault` and no `dvalid`.
  - `rd`+`wr` together give one `fault` and the array unchanged.
- Reset mid-read:
  - With `READ_LAT`=4, assert `reset` 2 cycles after `rd`.
  - Expect no `dvalid`, all outputs 0, and state IDLE.
  - A subsequent `astb`+`rd` returns the pre-reset array contents.
